// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : vga_pkg                                                  |
// | Shared constants for the VGA logo path: coordinate width, default  |
// | scroll bounds and the logo scroller state encoding.                |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package vga_pkg;

  // Horizontal coordinate width shared with the letter painters
  localparam int COORD_W = 11;

  // Default scroll geometry
  localparam int DEF_MAX_DELT     = 200;
  localparam int DEF_STEP         = 2;
  localparam int DEF_DWELL_FRAMES = 30;

  // Scroller state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RIGHT   = 3'd1;
  localparam state_t ST_DWELL_R = 3'd2;
  localparam state_t ST_LEFT    = 3'd3;
  localparam state_t ST_DWELL_L = 3'd4;

  function automatic logic is_dwell(input state_t st);
    return (st == ST_DWELL_R) || (st == ST_DWELL_L);
  endfunction

endpackage
`default_nettype wire

// File: rtl/logo_scroll_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface : logo_scroll_ctrl_if                                    |
// | Control/result bundle between VGA timing, the logo scroller and    |
// | the letter painters.                                               |
// |   enable, hold, frame_start, speed : controls into the scroller    |
// |   delt, dir, at_edge               : scroller outputs              |
// | master drives the controls, slave (the scroller) drives results.   |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
interface logo_scroll_ctrl_if;
  import vga_pkg::*;

  logic               enable;
  logic               hold;
  logic               frame_start;
  logic [3:0]         speed;
  logic [COORD_W-1:0] delt;
  logic               dir;
  logic               at_edge;

  modport master (
    output enable, hold, frame_start, speed,
    input  delt, dir, at_edge
  );

  modport slave (
    input  enable, hold, frame_start, speed,
    output delt, dir, at_edge
  );

endinterface
`default_nettype wire

// File: rtl/logo_scroll_ctrl_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : frame_divider                                             |
// | 4-bit programmable modulo counter. Each tick advances the count;   |
// | a tick seen while the count has reached speed is a due step and    |
// | returns the count to 0.                                            |
// |   clk, rst   : clock, asynchronous active-high reset               |
// |   tick_i     : one qualified frame event                           |
// |   clear_i    : synchronous clear (wins over tick_i)                |
// |   speed_i    : frames per step minus 1                             |
// |   due_o      : combinational, high on the tick that is a step      |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module frame_divider
  import vga_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       tick_i,
  input  wire logic       clear_i,
  input  wire logic [3:0] speed_i,
  output logic            due_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       at_limit;

  // ">=" rather than "==" so that lowering speed below the current count
  // makes the very next tick a step instead of wrapping through 15.
  assign at_limit = (cnt_q >= speed_i);
  assign due_o    = tick_i & ~clear_i & at_limit;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 4'd0;
    end else if (tick_i) begin
      cnt_d = at_limit ? 4'd0 : cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/logo_scroll_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : logo_scroll_ctrl                                          |
// | Produces the horizontal logo offset delt, bouncing between 0 and   |
// | MAX_DELT with a dwell at each end. delt only changes the cycle     |
// | after a qualified frame_start, so painters never see a torn frame. |
// |   clk, rst  : clock, asynchronous active-high reset                |
// |   scroll_if : slave side of logo_scroll_ctrl_if                    |
// |               in : enable, hold, frame_start, speed[3:0]           |
// |               out: delt[10:0], dir, at_edge (all registered)       |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module logo_scroll_ctrl
  import vga_pkg::*;
#(
  parameter int MAX_DELT     = DEF_MAX_DELT,
  parameter int STEP         = DEF_STEP,
  parameter int DWELL_FRAMES = DEF_DWELL_FRAMES
) (
  input wire logic          clk,
  input wire logic          rst,
  logo_scroll_ctrl_if.slave scroll_if
);

  localparam logic [11:0]        MAX_W12  = 12'(MAX_DELT);
  localparam logic [11:0]        STEP_W12 = 12'(STEP);
  localparam logic [COORD_W-1:0] MAX_C    = COORD_W'(MAX_DELT);
  localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP);
  localparam logic [8:0]         DWELL_W9 = 9'(DWELL_FRAMES);
  localparam logic               NO_DWELL = (DWELL_FRAMES == 0);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] delt_q,  delt_d;
  logic               dir_q,   dir_d;
  logic               at_edge_q, at_edge_d;
  logic [7:0]         dwell_q, dwell_d;

  logic               ev;
  logic               due;
  logic               moving;
  logic               dwell_last;
  logic               clamp_hi;
  logic               clamp_lo;
  state_t             eff_state;
  logic [11:0]        sum_w;

  assign ev = scroll_if.frame_start & scroll_if.enable & ~scroll_if.hold;

  // An event arriving in IDLE is handled as if already in the motion state
  // selected by dir, so the first event after enable can already step.
  assign eff_state = (state_q == ST_IDLE) ? (dir_q ? ST_LEFT : ST_RIGHT) : state_q;
  assign moving    = (eff_state == ST_RIGHT) || (eff_state == ST_LEFT);

  // 12-bit sum so delt + STEP near 2047 cannot wrap
  assign sum_w      = {1'b0, delt_q} + STEP_W12;
  assign clamp_hi   = (sum_w >= MAX_W12);
  assign clamp_lo   = (delt_q <= STEP_C);
  assign dwell_last = (({1'b0, dwell_q} + 9'd1) == DWELL_W9);

  // The divider only runs while moving; dwell ignores speed.
  frame_divider u_div (
    .clk     (clk),
    .rst     (rst),
    .tick_i  (ev & moving),
    .clear_i (~scroll_if.enable & ~scroll_if.hold),
    .speed_i (scroll_if.speed),
    .due_o   (due)
  );

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      delt_q    <= '0;
      dir_q     <= 1'b0;
      at_edge_q <= 1'b0;
      dwell_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      delt_q    <= delt_d;
      dir_q     <= dir_d;
      at_edge_q <= at_edge_d;
      dwell_q   <= dwell_d;
    end
  end

  // Next-state logic. hold freezes everything, including a pending disable.
  always_comb begin
    state_d = state_q;
    if (!scroll_if.hold) begin
      if (!scroll_if.enable) begin
        state_d = ST_IDLE;
      end else if (ev) begin
        state_d = eff_state;
        case (eff_state)
          ST_RIGHT:   if (due && clamp_hi) state_d = NO_DWELL ? ST_LEFT : ST_DWELL_R;
          ST_LEFT:    if (due && clamp_lo) state_d = NO_DWELL ? ST_RIGHT : ST_DWELL_L;
          ST_DWELL_R: if (dwell_last) state_d = ST_LEFT;
          ST_DWELL_L: if (dwell_last) state_d = ST_RIGHT;
          default:    state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Output / datapath logic
  always_comb begin
    delt_d  = delt_q;
    dir_d   = dir_q;
    dwell_d = dwell_q;
    if (!scroll_if.hold) begin
      if (!scroll_if.enable) begin
        dwell_d = 8'd0;
      end else if (ev) begin
        case (eff_state)
          ST_RIGHT: begin
            if (due) begin
              if (clamp_hi) begin
                delt_d  = MAX_C;
                dwell_d = 8'd0;
                if (NO_DWELL) dir_d = 1'b1;
              end else begin
                delt_d = sum_w[COORD_W-1:0];
              end
            end
          end
          ST_LEFT: begin
            if (due) begin
              if (clamp_lo) begin
                delt_d  = '0;
                dwell_d = 8'd0;
                if (NO_DWELL) dir_d = 1'b0;
              end else begin
                delt_d = delt_q - STEP_C;
              end
            end
          end
          ST_DWELL_R: begin
            if (dwell_last) begin
              dir_d   = 1'b1;
              dwell_d = 8'd0;
            end else begin
              dwell_d = dwell_q + 8'd1;
            end
          end
          ST_DWELL_L: begin
            if (dwell_last) begin
              dir_d   = 1'b0;
              dwell_d = 8'd0;
            end else begin
              dwell_d = dwell_q + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
    at_edge_d = is_dwell(state_d);
  end

  assign scroll_if.delt    = delt_q;
  assign scroll_if.dir     = dir_q;
  assign scroll_if.at_edge = at_edge_q;

endmodule
`default_nettype wire

// File: tb/tb_logo_scroll_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_logo_scroll_ctrl                                       |
// | Directed bench for logo_scroll_ctrl. Two instances share stimulus: |
// | A (MAX 200, STEP 2, DWELL 30) and B (MAX 201, STEP 2, DWELL 2).    |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_logo_scroll_ctrl;

  typedef struct {
    logic        en;
    logic        hold;
    logic [3:0]  spd;
    logic        fs;
    int          exp_delt;
    logic        exp_dir;
    logic        exp_edge;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       hld = 1'b0;
  logic       fs  = 1'b0;
  logic [3:0] spd = 4'd0;

  int errors = 0;
  int checks = 0;

  logo_scroll_ctrl_if ifa();
  logo_scroll_ctrl_if ifb();

  assign ifa.enable = en;  assign ifa.hold = hld;  assign ifa.frame_start = fs;  assign ifa.speed = spd;
  assign ifb.enable = en;  assign ifb.hold = hld;  assign ifb.frame_start = fs;  assign ifb.speed = spd;

  logo_scroll_ctrl #(.MAX_DELT(200), .STEP(2), .DWELL_FRAMES(30)) dut_a (
    .clk(clk), .rst(rst), .scroll_if(ifa.slave));

  logo_scroll_ctrl #(.MAX_DELT(201), .STEP(2), .DWELL_FRAMES(2)) dut_b (
    .clk(clk), .rst(rst), .scroll_if(ifb.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int d, input logic di, input logic e);
    chk({tag, " a_delt"}, int'(ifa.delt), d);
    chk({tag, " a_dir"}, int'(ifa.dir), int'(di));
    chk({tag, " a_edge"}, int'(ifa.at_edge), int'(e));
  endtask

  task automatic chk_b(input string tag, input int d, input logic di, input logic e);
    chk({tag, " b_delt"}, int'(ifb.delt), d);
    chk({tag, " b_dir"}, int'(ifb.dir), int'(di));
    chk({tag, " b_edge"}, int'(ifb.at_edge), int'(e));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the
  // rising edge that consumed frame_start.
  task automatic drive(input logic e, input logic h, input logic [3:0] s, input logic f);
    @(negedge clk);
    en = e; hld = h; spd = s; fs = f;
    @(posedge clk);
    #1;
    fs = 1'b0;
  endtask

  task automatic idle();
    repeat (8) @(posedge clk);
  endtask

  task automatic run_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 4'd0, 1'b1);
      idle();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; hld = 1'b0; fs = 1'b0; spd = 4'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic e, input logic h, input logic [3:0] s, input logic f,
                              input int d, input logic di, input logic ed);
    vec_t v;
    v.en = e; v.hold = h; v.spd = s; v.fs = f;
    v.exp_delt = d; v.exp_dir = di; v.exp_edge = ed;
    return v;
  endfunction

  task automatic run_table(input string tag, input vec_t tbl [$]);
    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].hold, tbl[i].spd, tbl[i].fs);
      chk_a($sformatf("%s[%0d]", tag, i), tbl[i].exp_delt, tbl[i].exp_dir, tbl[i].exp_edge);
      idle();
    end
  endtask

  initial begin
    vec_t t_speed [$];
    vec_t t_hold  [$];
    vec_t t_en    [$];
    int ea, eb;
    logic da, db, xa, xb;

    // Speed 3: step on every 4th event; speed drops to 1 with count 2 -> immediate step
    t_speed = '{
      mk(1,0,3,0,  0,0,0), mk(1,0,3,1,  0,0,0), mk(1,0,3,1,  0,0,0), mk(1,0,3,1,  0,0,0),
      mk(1,0,3,1,  2,0,0), mk(1,0,3,0,  2,0,0), mk(1,0,3,1,  2,0,0), mk(1,0,3,1,  2,0,0),
      mk(1,0,3,1,  2,0,0), mk(1,0,3,1,  4,0,0), mk(1,0,3,1,  4,0,0), mk(1,0,3,1,  4,0,0),
      mk(1,0,3,1,  4,0,0), mk(1,0,3,1,  6,0,0), mk(1,0,3,1,  6,0,0), mk(1,0,3,1,  6,0,0),
      mk(1,0,1,1,  8,0,0), mk(1,0,1,1,  8,0,0), mk(1,0,1,1, 10,0,0)
    };
    // From 50 with speed 1 (count 0): hold across 5 pulses freezes delt and divider
    t_hold = '{
      mk(1,0,1,1, 50,0,0), mk(1,1,1,1, 50,0,0), mk(1,1,1,1, 50,0,0), mk(1,1,1,1, 50,0,0),
      mk(1,1,1,1, 50,0,0), mk(1,1,1,1, 50,0,0), mk(1,0,1,1, 52,0,0), mk(1,0,1,1, 52,0,0),
      mk(1,0,1,1, 54,0,0)
    };
    // At 80 moving left: disable together with frame_start, then re-enable
    t_en = '{
      mk(0,0,0,1, 80,1,0), mk(0,0,0,1, 80,1,0), mk(1,0,0,0, 80,1,0),
      mk(1,0,0,1, 78,1,0), mk(1,0,0,1, 76,1,0)
    };

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    chk_a("por", 0, 1'b0, 1'b0);
    chk_b("por", 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Full bounce, speed 0, one frame_start every 10 cycles
    for (int n = 1; n <= 204; n++) begin
      drive(1'b1, 1'b0, 4'd0, 1'b1);
      if (n <= 100)      ea = 2 * n;
      else if (n <= 130) ea = 200;
      else               ea = 200 - 2 * (n - 130);
      da = (n >= 130);
      xa = (n >= 100) && (n <= 129);
      if (n <= 100)      eb = 2 * n;
      else if (n <= 103) eb = 201;
      else if (n <= 203) eb = 201 - 2 * (n - 103);
      else               eb = 0;
      db = (n >= 103);
      xb = (n == 101) || (n == 102) || (n == 204);
      chk_a($sformatf("bounce n=%0d", n), ea, da, xa);
      chk_b($sformatf("bounce n=%0d", n), eb, db, xb);
      idle();
      if (n == 50) chk("between pulses a_delt", int'(ifa.delt), 100);
    end

    do_reset();
    chk_a("rst2", 0, 1'b0, 1'b0);
    run_table("speed", t_speed);

    // Continue right at speed 0 from 10 up to 50
    run_pulses(20);
    chk_a("pre_hold", 50, 1'b0, 1'b0);
    run_table("hold", t_hold);

    // 54 -> 200 (73 steps), 30 dwell events, 200 -> 80 (60 steps)
    run_pulses(73 + 30 + 60);
    chk_a("pre_en", 80, 1'b1, 1'b0);
    run_table("enable", t_en);

    // Asynchronous reset mid-dwell at 200
    do_reset();
    run_pulses(105);
    chk_a("dwell", 200, 1'b0, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk_a("async_rst", 0, 1'b0, 1'b0);
    chk_b("async_rst", 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
